// File: rtl/godil_pkg.sv
// Shared types and defaults for the 6502 cycle sequencer.
package godil_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PH1  = 2'd1,
    PH2  = 2'd2
  } seq_state_e;

  localparam int HALFCYCLE_DEF = 30;
  localparam int GUARD_DEF     = 2;

endpackage

// File: rtl/halfcycle_timer.sv
// Half-cycle position counter: counts 0..HALFCYCLE-1 and wraps, held at 0 while clr is high.
module halfcycle_timer
  import godil_pkg::*;
#(
  parameter int HALFCYCLE = HALFCYCLE_DEF,
  parameter int CW        = $clog2(HALFCYCLE)
) (
  input  logic          eclk,
  input  logic          ereset_n,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  localparam logic [CW-1:0] LAST = CW'(HALFCYCLE - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || (cnt_q == LAST)) cnt_d = '0;
  end

  always_ff @(posedge eclk) begin
    if (!ereset_n) cnt_q <= '0;
    else           cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == LAST);

endmodule

// File: rtl/cpu_cycle_sequencer.sv
// Generates phi0 for the 6502 model and sequences run/halt/step bus cycles.
// state | meaning
// IDLE  | halted, phi0 stretched low
// PH1   | phi0 low half of a bus cycle
// PH2   | phi0 high half; data strobes live here
module cpu_cycle_sequencer
  import godil_pkg::*;
#(
  parameter int HALFCYCLE = HALFCYCLE_DEF,
  parameter int GUARD     = GUARD_DEF,
  parameter int CNT_W     = 32
) (
  input  logic             eclk,
  input  logic             ereset_n,
  input  logic             run,
  input  logic             step_req,
  input  logic             halt_on_sync,
  input  logic             sync_in,
  input  logic             rw_in,
  output logic             phi0,
  output logic             phi2_rise,
  output logic             phi2_fall,
  output logic             db_sample,
  output logic             db_oe,
  output logic             halted,
  output logic             step_ack,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int CW = $clog2(HALFCYCLE);
  localparam logic [CW-1:0] SYNC_AT   = CW'(HALFCYCLE - 2);
  localparam logic [CW-1:0] SAMPLE_AT = CW'(HALFCYCLE - 3);
  localparam logic [CW:0]   GUARD_W   = (CW+1)'(GUARD);

  seq_state_e       state_q, state_d;
  logic             step_q, step_d;
  logic             sync_q, sync_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             phi0_q, phi0_d, halted_q, halted_d;
  logic             rise_q, rise_d, fall_q, fall_d;
  logic             sample_q, sample_d, oe_q, oe_d, ack_q, ack_d;
  logic [CW-1:0]    cnt;
  logic             tc;

  halfcycle_timer #(.HALFCYCLE(HALFCYCLE), .CW(CW)) u_timer (
    .eclk     (eclk),
    .ereset_n (ereset_n),
    .clr      (state_q == IDLE),
    .cnt      (cnt),
    .tc       (tc)
  );

  // Outputs are computed for the state being entered so every output is a flop.
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    sync_d   = sync_q;
    count_d  = count_q;
    phi0_d   = 1'b0;
    halted_d = 1'b0;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    sample_d = 1'b0;
    oe_d     = 1'b0;
    ack_d    = 1'b0;
    case (state_q)
      IDLE: begin
        halted_d = 1'b1;
        if (run) begin
          state_d  = PH1;
          step_d   = 1'b0;
          halted_d = 1'b0;
        end else if (step_req) begin
          state_d  = PH1;
          step_d   = 1'b1;
          halted_d = 1'b0;
        end
      end
      PH1: begin
        if (tc) begin
          state_d = PH2;
          phi0_d  = 1'b1;
          rise_d  = 1'b1;
        end
      end
      PH2: begin
        phi0_d = 1'b1;
        if (cnt == SYNC_AT) sync_d = sync_in;
        if ((cnt == SAMPLE_AT) && rw_in) sample_d = 1'b1;
        if (!tc && (({1'b0, cnt} + 1'b1) >= GUARD_W) && !rw_in) oe_d = 1'b1;
        if (tc) begin
          phi0_d  = 1'b0;
          fall_d  = 1'b1;
          count_d = count_q + 1'b1;
          if (step_q || !run || (halt_on_sync && sync_q)) begin
            state_d  = IDLE;
            halted_d = 1'b1;
            ack_d    = step_q;
            step_d   = 1'b0;
          end else begin
            state_d = PH1;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        halted_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge eclk) begin
    if (!ereset_n) begin
      state_q  <= IDLE;
      step_q   <= 1'b0;
      sync_q   <= 1'b0;
      count_q  <= '0;
      phi0_q   <= 1'b0;
      halted_q <= 1'b1;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      sample_q <= 1'b0;
      oe_q     <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      sync_q   <= sync_d;
      count_q  <= count_d;
      phi0_q   <= phi0_d;
      halted_q <= halted_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      sample_q <= sample_d;
      oe_q     <= oe_d;
      ack_q    <= ack_d;
    end
  end

  assign phi0        = phi0_q;
  assign phi2_rise   = rise_q;
  assign phi2_fall   = fall_q;
  assign db_sample   = sample_q;
  assign db_oe       = oe_q;
  assign halted      = halted_q;
  assign step_ack    = ack_q;
  assign cycle_count = count_q;

endmodule

// File: tb/tb_cpu_cycle_sequencer.sv
// Bench for cpu_cycle_sequencer with HALFCYCLE=4, GUARD=1: scenario table plus random run.
module tb_cpu_cycle_sequencer;

  localparam int H = 4;
  localparam int G = 1;

  logic        eclk;
  logic        rst_r, run_r, step_r, hos_r, sync_r, rw_r;
  logic        phi0, phi2_rise, phi2_fall, db_sample, db_oe, halted, step_ack;
  logic [31:0] cycle_count;

  cpu_cycle_sequencer #(.HALFCYCLE(H), .GUARD(G), .CNT_W(32)) dut (
    .eclk         (eclk),
    .ereset_n     (rst_r),
    .run          (run_r),
    .step_req     (step_r),
    .halt_on_sync (hos_r),
    .sync_in      (sync_r),
    .rw_in        (rw_r),
    .phi0         (phi0),
    .phi2_rise    (phi2_rise),
    .phi2_fall    (phi2_fall),
    .db_sample    (db_sample),
    .db_oe        (db_oe),
    .halted       (halted),
    .step_ack     (step_ack),
    .cycle_count  (cycle_count)
  );

  initial eclk = 1'b0;
  always #5 eclk = ~eclk;

  int tests = 0;
  int fails = 0;

  // Reference: position within the 2*H eclk bus cycle, -1 when halted.
  int          m_pos = -1;
  bit          m_step = 0, m_sync = 0, m_fall = 0, m_ack = 0, m_sample = 0, m_oe = 0;
  logic [31:0] m_count = 0;
  int          rises = 0, acks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_step();
    m_fall = 0;
    m_ack  = 0;
    if (!rst_r) begin
      m_pos = -1; m_count = 0; m_step = 0; m_sync = 0;
    end else if (m_pos < 0) begin
      if (run_r) begin
        m_pos = 0; m_step = 0;
      end else if (step_r) begin
        m_pos = 0; m_step = 1;
      end
    end else begin
      if (m_pos == 2*H-2) m_sync = sync_r;
      if (m_pos == 2*H-1) begin
        m_count = m_count + 1;
        m_fall  = 1;
        if (m_step || !run_r || (hos_r && m_sync)) begin
          m_ack = m_step; m_step = 0; m_pos = -1;
        end else begin
          m_pos = 0;
        end
      end else begin
        m_pos++;
      end
    end
    m_sample = (m_pos == 2*H-2) && rw_r;
    m_oe     = (m_pos >= H+G) && !rw_r;
  endtask

  task automatic tick();
    @(posedge eclk);
    model_step();
    #1;
    rises += int'(phi2_rise);
    acks  += int'(step_ack);
    check("phi0",        32'(phi0),      32'(m_pos >= H));
    check("halted",      32'(halted),    32'(m_pos < 0));
    check("phi2_rise",   32'(phi2_rise), 32'(m_pos == H));
    check("phi2_fall",   32'(phi2_fall), 32'(m_fall));
    check("db_sample",   32'(db_sample), 32'(m_sample));
    check("db_oe",       32'(db_oe),     32'(m_oe));
    check("step_ack",    32'(step_ack),  32'(m_ack));
    check("cycle_count", cycle_count,    m_count);
  endtask

  typedef struct {
    logic        rst_n, run, step, hos, sync, rw;
    int          n;
    logic        e_halted, e_phi0, e_oe;
    logic [31:0] e_count;
    int          e_rises, e_acks;
  } vec_t;

  vec_t vecs[18];

  initial begin
    //             rst run stp hos syn rw   n  hlt phi oe  cnt rise ack
    vecs[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,  3, 1'b1,1'b0,1'b0, 0, 0, 0};
    vecs[1]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 20, 1'b1,1'b0,1'b0, 0, 0, 0};
    vecs[2]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b1, 40, 1'b0,1'b1,1'b0, 4, 5, 0};
    vecs[3]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1, 10, 1'b1,1'b0,1'b0, 5, 0, 0};
    vecs[4]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,  2, 1'b1,1'b0,1'b0, 0, 0, 0};
    vecs[5]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b1, 17, 1'b0,1'b0,1'b0, 2, 2, 0};
    vecs[6]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1, 12, 1'b1,1'b0,1'b0, 3, 1, 0};
    vecs[7]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,  1, 1'b0,1'b0,1'b0, 3, 0, 0};
    vecs[8]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,  1, 1'b0,1'b0,1'b0, 3, 0, 0};
    vecs[9]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1, 10, 1'b1,1'b0,1'b0, 4, 1, 1};
    vecs[10] = '{1'b1,1'b1,1'b0,1'b1,1'b0,1'b1, 21, 1'b0,1'b1,1'b0, 6, 3, 0};
    vecs[11] = '{1'b1,1'b1,1'b0,1'b1,1'b1,1'b1,  4, 1'b1,1'b0,1'b0, 7, 0, 0};
    vecs[12] = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,  4, 1'b1,1'b0,1'b0, 7, 0, 0};
    vecs[13] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 13, 1'b0,1'b1,1'b0, 8, 2, 0};
    vecs[14] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,  1, 1'b0,1'b1,1'b1, 8, 0, 0};
    vecs[15] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,  1, 1'b0,1'b1,1'b0, 8, 0, 0};
    vecs[16] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,  1, 1'b1,1'b0,1'b0, 0, 0, 0};
    vecs[17] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,  5, 1'b1,1'b0,1'b0, 0, 0, 0};

    rst_r = 0; run_r = 0; step_r = 0; hos_r = 0; sync_r = 0; rw_r = 0;
    #2;

    for (int v = 0; v < 18; v++) begin
      rst_r  = vecs[v].rst_n;
      run_r  = vecs[v].run;
      step_r = vecs[v].step;
      hos_r  = vecs[v].hos;
      sync_r = vecs[v].sync;
      rw_r   = vecs[v].rw;
      rises  = 0;
      acks   = 0;
      for (int c = 0; c < vecs[v].n; c++) tick();
      check($sformatf("vec%0d halted", v),      32'(halted),  32'(vecs[v].e_halted));
      check($sformatf("vec%0d phi0", v),        32'(phi0),    32'(vecs[v].e_phi0));
      check($sformatf("vec%0d db_oe", v),       32'(db_oe),   32'(vecs[v].e_oe));
      check($sformatf("vec%0d cycle_count", v), cycle_count,  vecs[v].e_count);
      check($sformatf("vec%0d rises", v),       32'(rises),   32'(vecs[v].e_rises));
      check($sformatf("vec%0d acks", v),        32'(acks),    32'(vecs[v].e_acks));
    end

    // Stepped cycle from idle: ack lands exactly 2*H edges after the edge that takes the request.
    step_r = 1;
    tick();
    step_r = 0;
    acks = 0;
    for (int c = 1; c < 2*H; c++) tick();
    check("step no early ack", 32'(acks), 32'd0);
    tick();
    check("step ack at 2H", 32'(step_ack), 32'd1);
    check("step halted at 2H", 32'(halted), 32'd1);
    check("step fall at 2H", 32'(phi2_fall), 32'd1);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) run_r = ~run_r;
      if ($urandom_range(0, 49) == 0) hos_r = ~hos_r;
      step_r = ($urandom_range(0, 7) == 0);
      sync_r = ($urandom_range(0, 3) == 0);
      rw_r   = 1'($urandom_range(0, 1));
      rst_r  = ($urandom_range(0, 299) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cpu_cycle_sequencer.md
# cpu_cycle_sequencer

Generates the emulated 6502 input clock (phi0) from the emulation clock and sequences each bus cycle: run/halt/single-step control, instruction-boundary halt, read-data sample strobe and guarded data-bus output enable. Sits between the board top level and the `chip_6502` netlist model. It replaces the free-running external clk0 when the board runs under host/debugger control. All timing is counted in `eclk` periods, `HALFCYCLE` per phi0 half.

## Interface
Parameters:
- `HALFCYCLE`, 30: eclk cycles per phi0 half-cycle; legal range ≥ 4.
- `GUARD`, 2: eclk cycles after phi0 rise before `db_oe` may assert; legal range 1 .. HALFCYCLE-2.
- `CNT_W`, 32: width of `cycle_count`.

Ports:
- `eclk` in 1: emulation clock. One clock domain only.
- `ereset_n` in 1: synchronous, active-low reset.
- `run` in 1: level; free-run request.
- `step_req` in 1: single-cycle pulse; requests one bus cycle while halted.
- `halt_on_sync` in 1: level; stop after any cycle with `sync_in` high.
- `sync_in` in 1: `sync` from the model.
- `rw_in` in 1: `rw` from the model; 1 = read.
- `phi0` out 1: emulated clk0 to the model.
- `phi2_rise` out 1: one-eclk pulse on the first eclk with phi0 high.
- `phi2_fall` out 1: one-eclk pulse on the first eclk of the following low phase or halt.
- `db_sample` out 1: one-eclk pulse for latching read data.
- `db_oe` out 1: data-bus drive enable.
- `halted` out 1: sequencer is idle with phi0 low.
- `step_ack` out 1: one-eclk pulse when a stepped cycle completes.
- `cycle_count` out CNT_W: completed bus cycles.

## Operation
- States: IDLE, PH1 (phi0 = 0), PH2 (phi0 = 1). A half-cycle counter `cnt` runs 0..HALFCYCLE-1.
- Reset (`ereset_n` = 0 at an edge):
  - Next state is IDLE, whatever the current state; no partial cycle completes.
  - Output values: phi0 = 0, halted = 1, cnt = 0, cycle_count = 0, db_oe = 0. All pulses are 0.
- IDLE:
  - phi0 held low (stretched phi1); `halted` = 1.
  - `run` = 1: go to PH1 with cnt = 0.
  - Otherwise, `step_req` = 1: latch the step flag and go to PH1.
  - `run` and `step_req` both high: `run` wins, the step flag is not set, and no `step_ack` is generated.
- PH1: at cnt = HALFCYCLE-1, go to PH2 with cnt = 0.
- PH2, at cnt = HALFCYCLE-1 (cycle end):
  - `cycle_count` increments and wraps modulo 2^CNT_W.
  - Halt condition: step flag set, or `run` = 0, or (`halt_on_sync` = 1 and `sync_in` was sampled high at cnt = HALFCYCLE-2 of this PH2).
  - Halt condition true: go to IDLE; pulse `step_ack` if the step flag was set; clear the step flag.
  - Otherwise: go to PH1.
- `step_req` outside IDLE is ignored and not queued.
- Deasserting `run` mid-cycle completes the current cycle, then halts.
- `db_sample` pulses in PH2 at cnt = HALFCYCLE-2 when `rw_in` = 1.
- `db_oe` = 1 in PH2 while cnt ≥ GUARD and `rw_in` = 0. It is 0 in PH1, in IDLE, and for the first GUARD eclks of PH2 (turnaround guard).

## Timing
- All outputs are registered. No combinational path from any input to any output.
- From `step_req` sampled in IDLE:
  - `halted` falls and PH1 begins on the next edge.
  - phi0 stays low for HALFCYCLE eclks, then high for HALFCYCLE eclks.
  - On the following edge, `halted` = 1, `step_ack` = 1 and `phi2_fall` = 1 together.
- Full bus cycle = 2·HALFCYCLE eclks; no dead cycles between consecutive running cycles.
- `phi2_rise` coincides with the first eclk of phi0 = 1. `phi2_fall` coincides with the first eclk of phi0 = 0.
- `db_oe` deasserts on the same edge that phi0 falls.

## Structure
- Shared package `godil_pkg`:
  - Sequencer state enum (IDLE, PH1, PH2).
  - Default HALFCYCLE = 30 constant.
  - Default GUARD constant.
- Sub-module `halfcycle_timer`: loadable counter with a terminal-count flag, parameterised by HALFCYCLE. The FSM, strobes and `cycle_count` stay in the top module.

## Test plan
All scenarios use HALFCYCLE = 4, GUARD = 1.
- Reset release, no inputs: phi0 = 0, halted = 1, cycle_count = 0 held for 20 eclks; all pulses 0.
- `run` = 1 for 40 eclks:
  - phi0 period is 8 eclks, duty 4/4.
  - 5 `phi2_rise` pulses.
  - Drop `run` at eclk 18: the cycle in progress completes, then halted = 1, cycle_count = 3.
- `step_req` pulse while halted:
  - Exactly one 8-eclk cycle; `step_ack` on eclk 9 after the request; cycle_count += 1.
  - Second `step_req` issued mid-cycle: ignored, and no further cycle runs.
- `run` = 1, `halt_on_sync` = 1, `sync_in` high during the 3rd cycle's PH2: halts after cycle 3, cycle_count = 3, no `step_ack`.
- `rw_in` = 0 across PH2: `db_oe` high PH2 cnt 1..3, low elsewhere. With `rw_in` = 1: `db_sample` at PH2 cnt 2 only, and `db_oe` never asserts.
- `ereset_n` asserted at PH2 cnt 2 while running: next edge IDLE, phi0 = 0, db_oe = 0, cycle_count = 0, no `step_ack`.
